// File: rtl/serial_compare.sv
// serial_compare: bit-serial magnitude comparator, LSB first.
//
// Captures two BITS-wide operands on an accepted start and scans one bit per
// clock. Because later (higher) bits overwrite the running less-than flag, the
// most significant differing bit decides the result. In signed mode the sign
// bit is treated inversely: a set sign bit on A means A is the smaller value.
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   a_i, b_i  - operands, sampled only on an accepted start
//   mode_i    - 0 = unsigned, 1 = two's-complement signed (sampled on start)
//   start_i   - comparison request, honoured only in idle
//   busy_o    - high while a comparison is in flight (run and done cycles)
//   done_o    - one-cycle pulse; results valid from this cycle on
//   less_o    - A < B for the last completed comparison
//   equal_o   - A == B for the last completed comparison
//   greater_o - A > B for the last completed comparison
module serial_compare #(
  parameter int unsigned BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [BITS-1:0] a_i,
  input  logic [BITS-1:0] b_i,
  input  logic            mode_i,
  input  logic            start_i,
  output logic            busy_o,
  output logic            done_o,
  output logic            less_o,
  output logic            equal_o,
  output logic            greater_o
);

  localparam int unsigned CntW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(BITS - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [BITS-1:0] sa_q, sb_q;
  logic            mode_q;
  logic [CntW-1:0] cnt_q;
  logic            lt_q, eq_q;
  logic            busy_q, done_q, less_q, equal_q, greater_q;

  logic a_bit, b_bit, bit_diff, msb;
  logic lt_d, eq_d;

  // Per-bit step of the scan; used by the run state below.
  always_comb begin
    a_bit    = sa_q[0];
    b_bit    = sb_q[0];
    bit_diff = a_bit ^ b_bit;
    msb      = (cnt_q == LastCnt);
    lt_d     = lt_q;
    if (bit_diff) begin
      // On the sign bit a set A bit means A is negative, hence smaller.
      lt_d = (msb && mode_q) ? a_bit : b_bit;
    end
    eq_d = eq_q & ~bit_diff;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      sa_q      <= '0;
      sb_q      <= '0;
      mode_q    <= 1'b0;
      cnt_q     <= '0;
      lt_q      <= 1'b0;
      eq_q      <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      less_q    <= 1'b0;
      equal_q   <= 1'b0;
      greater_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          done_q <= 1'b0;
          if (start_i) begin
            sa_q    <= a_i;
            sb_q    <= b_i;
            mode_q  <= mode_i;
            lt_q    <= 1'b0;
            eq_q    <= 1'b1;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + 1'b1;
          lt_q  <= lt_d;
          eq_q  <= eq_d;
          if (msb) begin
            // Results change only here, so they hold until the next done.
            less_q    <= lt_d;
            equal_q   <= eq_d;
            greater_q <= ~lt_d & ~eq_d;
            done_q    <= 1'b1;
            state_q   <= StDone;
          end
        end
        StDone: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign less_o    = less_q;
  assign equal_o   = equal_q;
  assign greater_o = greater_q;

endmodule
